// File: rtl/mmp_iddmm_host.sv
// Host-side initiator for the IDDMM Montgomery core: streams x/y/m into the core RAMs,
// requests the task, buffers the result words and replays them on a valid/ready stream.
module mmp_iddmm_host #(
  parameter int unsigned K      = 128,
  parameter int unsigned N      = 32,
  parameter int unsigned ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic              cmd_keep_m,
  input  logic [K-1:0]      cmd_m1,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [K-1:0]      s_data,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [K-1:0]      r_data,
  output logic              r_last,
  output logic              busy,
  output logic              err,
  output logic [2:0]        core_wr_ena,
  output logic [ADDR_W-1:0] core_wr_addr,
  output logic [K-1:0]      core_wr_x,
  output logic [K-1:0]      core_wr_y,
  output logic [K-1:0]      core_wr_m,
  output logic [K-1:0]      core_wr_m1,
  output logic              core_task_req,
  input  logic              core_task_end,
  input  logic              core_task_grant,
  input  logic [K-1:0]      core_task_res
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N - 1);
  localparam logic [CntW-1:0]   FullCnt  = CntW'(N);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StDrain} state_e;

  state_e              state_q, state_d;
  logic [1:0]          phase_q, phase_d;
  logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
  logic                keep_q, keep_d;
  logic                m_loaded_q, m_loaded_d;
  logic [K-1:0]        m1_q, m1_d;
  logic                err_q, err_d;
  logic [2:0]          wr_ena_q, wr_ena_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [K-1:0]        wr_data_q, wr_data_d;
  logic                req_q, req_d;
  logic [CntW-1:0]     grant_cnt_q, grant_cnt_d;
  logic [ADDR_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                buf_we;
  logic [K-1:0]        buf_q [N];

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    word_cnt_d  = word_cnt_q;
    keep_d      = keep_q;
    m_loaded_d  = m_loaded_q;
    m1_d        = m1_q;
    err_d       = err_q;
    wr_ena_d    = '0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    req_d       = req_q;
    grant_cnt_d = grant_cnt_q;
    drain_cnt_d = drain_cnt_q;
    buf_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_start) begin
          state_d     = StLoad;
          err_d       = 1'b0;
          word_cnt_d  = '0;
          grant_cnt_d = '0;
          drain_cnt_d = '0;
          phase_d     = 2'd0;
          keep_d      = cmd_keep_m & m_loaded_q;
          if (!(cmd_keep_m & m_loaded_q)) m1_d = cmd_m1;
        end
      end
      StLoad: begin
        if (s_valid) begin
          wr_ena_d   = 3'd1 << phase_q;
          wr_addr_d  = word_cnt_q;
          wr_data_d  = s_data;
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == LastAddr) begin
            word_cnt_d = '0;
            phase_d    = phase_q + 2'd1;
            if ((phase_q == 2'd1 && keep_q) || phase_q == 2'd2) begin
              state_d = StStart;
              if (phase_q == 2'd2) m_loaded_d = 1'b1;
            end
          end
        end
      end
      StStart: begin
        req_d   = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        // A grant in the same cycle as end is counted before the end check.
        if (core_task_grant) begin
          if (grant_cnt_q < FullCnt) begin
            buf_we      = 1'b1;
            grant_cnt_d = grant_cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (core_task_end) begin
          req_d   = 1'b0;
          state_d = StDrain;
          if (grant_cnt_d != FullCnt) err_d = 1'b1;
        end
      end
      StDrain: begin
        if (r_ready) begin
          if (drain_cnt_q == LastAddr) begin
            drain_cnt_d = '0;
            state_d     = StIdle;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_q     <= 2'd0;
      word_cnt_q  <= '0;
      keep_q      <= 1'b0;
      m_loaded_q  <= 1'b0;
      m1_q        <= '0;
      err_q       <= 1'b0;
      wr_ena_q    <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      req_q       <= 1'b0;
      grant_cnt_q <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      word_cnt_q  <= word_cnt_d;
      keep_q      <= keep_d;
      m_loaded_q  <= m_loaded_d;
      m1_q        <= m1_d;
      err_q       <= err_d;
      wr_ena_q    <= wr_ena_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      req_q       <= req_d;
      grant_cnt_q <= grant_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) buf_q[i] <= '0;
    end else if (buf_we) begin
      buf_q[grant_cnt_q[ADDR_W-1:0]] <= core_task_res;
    end
  end

  assign s_ready       = (state_q == StLoad);
  assign r_valid       = (state_q == StDrain);
  assign r_last        = r_valid && (drain_cnt_q == LastAddr);
  assign r_data        = buf_q[drain_cnt_q];
  assign busy          = (state_q != StIdle);
  assign err           = err_q;
  assign core_wr_ena   = wr_ena_q;
  assign core_wr_addr  = wr_addr_q;
  assign core_wr_x     = wr_data_q;
  assign core_wr_y     = wr_data_q;
  assign core_wr_m     = wr_data_q;
  // The core latches m1 on any write, so it is always presented.
  assign core_wr_m1    = m1_q;
  assign core_task_req = req_q;

endmodule

// File: tb/tb_mmp_iddmm_host.sv
// Directed bench for mmp_iddmm_host with a queue-based write/result model and stub core.
module tb_mmp_iddmm_host;

  localparam int K = 128;
  localparam int N = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_start = 1'b0, cmd_keep_m = 1'b0;
  logic [K-1:0]  cmd_m1 = '0;
  logic          s_valid = 1'b0, s_ready;
  logic [K-1:0]  s_data = '0;
  logic          r_valid, r_ready = 1'b0, r_last, busy, err;
  logic [K-1:0]  r_data;
  logic [2:0]    core_wr_ena;
  logic [AW-1:0] core_wr_addr;
  logic [K-1:0]  core_wr_x, core_wr_y, core_wr_m, core_wr_m1;
  logic          core_task_req, core_task_end = 1'b0, core_task_grant = 1'b0;
  logic [K-1:0]  core_task_res = '0;

  mmp_iddmm_host #(.K(K), .N(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_keep_m(cmd_keep_m), .cmd_m1(cmd_m1),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
    .busy(busy), .err(err), .core_wr_ena(core_wr_ena), .core_wr_addr(core_wr_addr),
    .core_wr_x(core_wr_x), .core_wr_y(core_wr_y), .core_wr_m(core_wr_m),
    .core_wr_m1(core_wr_m1), .core_task_req(core_task_req), .core_task_end(core_task_end),
    .core_task_grant(core_task_grant), .core_task_res(core_task_res)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state
  bit           m_loaded_m = 0;
  bit           keep_eff = 0;
  logic [K-1:0] m1_m = '0;
  logic [K-1:0] mbuf [N];
  logic [2:0]   exp_ena  [$];
  logic [AW-1:0] exp_addr [$];
  logic [K-1:0] exp_data [$];
  logic [K-1:0] exp_res  [$];
  bit           exp_last [$];
  logic [K-1:0] first_d, last_d;
  bit           last_flag;

  task automatic check(input string name, input logic [K-1:0] got, input logic [K-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Compare process: every write pulse and every result handshake against the model.
  bit           prev_stall = 0;
  logic [K-1:0] prev_data;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (core_wr_ena != 3'b000) begin
          if (exp_ena.size() == 0) begin
            check("unexpected_write", {125'd0, core_wr_ena}, '0);
          end else begin
            check("wr_ena", {125'd0, core_wr_ena}, {125'd0, exp_ena.pop_front()});
            check("wr_addr", {123'd0, core_wr_addr}, {123'd0, exp_addr.pop_front()});
            check("wr_x", core_wr_x, exp_data[0]);
            check("wr_y", core_wr_y, exp_data[0]);
            check("wr_m", core_wr_m, exp_data.pop_front());
            check("wr_m1", core_wr_m1, m1_m);
          end
        end
        if (r_valid && r_ready) begin
          if (exp_res.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            check("r_data", r_data, exp_res.pop_front());
            check("r_last", {127'd0, r_last}, {127'd0, exp_last.pop_front()});
          end
        end
        if (prev_stall && r_valid) check("r_data_stable", r_data, prev_data);
        prev_stall = r_valid && !r_ready;
        prev_data  = r_data;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {127'd0, busy}, 0);
    check({tag, "_s_ready"}, {127'd0, s_ready}, 0);
    check({tag, "_r_valid"}, {127'd0, r_valid}, 0);
    check({tag, "_r_last"}, {127'd0, r_last}, 0);
    check({tag, "_r_data"}, r_data, 0);
    check({tag, "_err"}, {127'd0, err}, 0);
    check({tag, "_wr_ena"}, {125'd0, core_wr_ena}, 0);
    check({tag, "_wr_addr"}, {123'd0, core_wr_addr}, 0);
    check({tag, "_wr_x"}, core_wr_x, 0);
    check({tag, "_wr_m1"}, core_wr_m1, 0);
    check({tag, "_req"}, {127'd0, core_task_req}, 0);
  endtask

  task automatic start_cmd(input bit keep, input logic [K-1:0] m1);
    cmd_start = 1; cmd_keep_m = keep; cmd_m1 = m1;
    keep_eff = keep && m_loaded_m;
    if (!keep_eff) m1_m = m1;
    @(posedge clk); #1;
    cmd_start = 0; cmd_keep_m = 0;
    @(negedge clk);
    check("err_cleared", {127'd0, err}, 0);
    check("busy_load", {127'd0, busy}, 1);
    @(posedge clk); #1;
  endtask

  // Streams x,y[,m] words; checks s_ready drop and request latency after the last word.
  task automatic load(input logic [K-1:0] seed, input bit gap);
    int nwords = keep_eff ? 2 * N : 3 * N;
    int k = 0;
    int cyc = 0;
    bit hs;
    while (k < nwords && cyc < 1000) begin
      s_valid = !(gap && (cyc % 2 == 1));
      s_data  = seed + K'((k / N) * 256 + (k % N));
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk); #1;
      if (hs) begin
        exp_ena.push_back(3'd1 << (k / N));
        exp_addr.push_back(AW'(k % N));
        exp_data.push_back(s_data);
        k++;
      end
      cyc++;
    end
    s_valid = 0;
    check("words_accepted", k, nwords);
    if (!keep_eff) m_loaded_m = 1;
    @(negedge clk);
    check("s_ready_dropped", {127'd0, s_ready}, 0);
    check("req_not_yet", {127'd0, core_task_req}, 0);
    @(negedge clk);
    check("req_t_plus_2", {127'd0, core_task_req}, 1);
    check("writes_all_seen", exp_ena.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic core_run(input int ng, input logic [K-1:0] base, input bit same);
    for (int i = 0; i < ng; i++) begin
      core_task_grant = 1; core_task_res = base + K'(i);
      core_task_end = same && (i == ng - 1);
      if (i < N) mbuf[i] = base + K'(i);
      @(posedge clk); #1;
    end
    core_task_grant = 0; core_task_end = 0;
    if (!same || ng == 0) begin
      core_task_end = 1;
      @(posedge clk); #1;
      core_task_end = 0;
    end
    for (int i = 0; i < N; i++) begin
      exp_res.push_back(mbuf[i]);
      exp_last.push_back(i == N - 1);
    end
    @(negedge clk);
    check("req_dropped", {127'd0, core_task_req}, 0);
    check("err_after_end", {127'd0, err}, {127'd0, ng != N});
    check("r_valid_drain", {127'd0, r_valid}, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input bit toggle);
    int n = 0;
    int cyc = 0;
    while (n < N && cyc < 300) begin
      r_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (r_valid && r_ready) begin
        if (n == 0) first_d = r_data;
        if (n == N - 1) begin last_d = r_data; last_flag = r_last; end
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    r_ready = 0;
    check("drain_count", n, N);
    check("results_all_seen", exp_res.size(), 0);
    @(negedge clk);
    check("idle_after_drain", {127'd0, busy}, 0);
    @(posedge clk); #1;
  endtask

  task automatic run(input bit keep, input logic [K-1:0] m1, input logic [K-1:0] seed,
                     input bit gap, input int ng, input logic [K-1:0] base, input bit same,
                     input bit toggle);
    start_cmd(keep, m1);
    load(seed, gap);
    core_run(ng, base, same);
    drain(toggle);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) mbuf[i] = '0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // 1: full load, 32 grants then separate end
    run(0, 128'h1111, 128'h0, 0, 32, 128'hA0, 0, 0);
    check("run1_first", first_d, 128'hA0);
    check("run1_last", last_d, 128'hBF);
    check("run1_last_flag", {127'd0, last_flag}, 1);
    check("run1_err", {127'd0, err}, 0);

    // 2: keep m; m1 must not follow cmd_m1
    run(1, 128'hDEAD, 128'h1000, 0, 32, 128'hC0, 1, 0);
    check("run2_m1_kept", core_wr_m1, 128'h1111);
    check("run2_first", first_d, 128'hC0);

    // 4: gapped operand stream, toggled r_ready
    run(1, 128'h0, 128'h2000, 1, 32, 128'hE0, 0, 1);
    check("run4_last", last_d, 128'hFF);

    // 5a: short grant count; word 31 keeps the previous result
    run(0, 128'h2222, 128'h3000, 0, 31, 128'h300, 1, 0);
    check("run5a_err", {127'd0, err}, 1);
    check("run5a_stale_last", last_d, 128'hFF);
    check("run5a_first", first_d, 128'h300);

    // 5b: start clears err; 33 grants, extra dropped
    run(1, 128'h0, 128'h4000, 0, 33, 128'h400, 0, 0);
    check("run5b_err", {127'd0, err}, 1);
    check("run5b_last", last_d, 128'h41F);

    // 6: cmd_start in WAIT ignored, then reset mid-operation
    start_cmd(0, 128'h3333);
    load(128'h5000, 0);
    cmd_start = 1; cmd_keep_m = 0; cmd_m1 = 128'h9999;
    @(posedge clk); #1;
    cmd_start = 0;
    repeat (3) begin
      @(negedge clk);
      check("wait_busy", {127'd0, busy}, 1);
      check("wait_s_ready", {127'd0, s_ready}, 0);
      check("wait_req", {127'd0, core_task_req}, 1);
    end
    @(posedge clk); #1;
    rst = 1;
    m_loaded_m = 0; m1_m = '0;
    for (int i = 0; i < N; i++) mbuf[i] = '0;
    @(negedge clk);
    check_zero("midrst");
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // 3: keep_m right after reset must stream m
    run(1, 128'h4444, 128'h6000, 0, 32, 128'h500, 0, 0);
    check("run3_err", {127'd0, err}, 0);
    check("run3_m1", core_wr_m1, 128'h4444);
    check("run3_last", last_d, 128'h51F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
